// File: rtl/rsa_modexp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rsa_modexp_ctrl
// Brief    : Left-to-right square-and-multiply sequencer for base^exp mod n,
//            issuing every reduction to an external mod_module.
//            Optional build macro: MODEXP_SKIP_LZ_EN (skip leading exp zeros).
// Revision : 1.0 - initial release
// ============================================================================
module rsa_modexp_ctrl #(
  parameter int BITS     = 32,
  parameter int EXP_BITS = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_start,
  input  logic [BITS-1:0]     i_base,
  input  logic [EXP_BITS-1:0] i_exp,
  input  logic [BITS-1:0]     i_modulus,
  output logic                o_busy,
  output logic                o_done,
  output logic [BITS-1:0]     o_result,
  output logic                o_err,
  output logic                o_mod_start,
  output logic [2*BITS-1:0]   o_mod_dividend,
  output logic [BITS-1:0]     o_mod_divisor,
  input  logic [BITS-1:0]     i_mod_remainder,
  input  logic                i_mod_done
);

  localparam int              c_IW    = (EXP_BITS > 1) ? $clog2(EXP_BITS) : 1;
  localparam logic [c_IW-1:0] c_I_TOP = c_IW'(EXP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_GAP   = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    OP_LOAD = 2'd0,
    OP_SQR  = 2'd1,
    OP_MUL  = 2'd2
  } op_t;

  state_t              r_state;
  op_t                 r_op;
  logic [c_IW-1:0]     r_i;
  logic [BITS-1:0]     r_base;
  logic [EXP_BITS-1:0] r_exp;
  logic [BITS-1:0]     r_acc;
  logic [BITS-1:0]     r_bred;
  logic                r_busy;
  logic                r_done;
  logic [BITS-1:0]     r_result;
  logic                r_err;
  logic                r_mod_start;
  logic [2*BITS-1:0]   r_mod_dividend;
  logic [BITS-1:0]     r_mod_divisor;

  logic                w_next_mul;
  logic [BITS-1:0]     w_mul_b;
  logic [2*BITS-1:0]   w_prod;
  logic [c_IW-1:0]     w_first_i;

  // Operand for the op that GAP is about to issue: a multiply follows a square
  // only when the current exponent bit is set, otherwise it is another square.
  assign w_next_mul = (r_op == OP_SQR) && r_exp[r_i];
  assign w_mul_b    = w_next_mul ? r_bred : r_acc;
  assign w_prod     = {{BITS{1'b0}}, r_acc} * {{BITS{1'b0}}, w_mul_b};

`ifdef MODEXP_SKIP_LZ_EN
  logic [c_IW-1:0] w_msb;

  always_comb begin
    w_msb = '0;
    for (int k = 0; k < EXP_BITS; k++) begin
      if (r_exp[k]) w_msb = c_IW'(k);
    end
  end

  assign w_first_i = w_msb;
`else
  assign w_first_i = c_I_TOP;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_op           <= OP_LOAD;
      r_i            <= '0;
      r_base         <= '0;
      r_exp          <= '0;
      r_acc          <= '0;
      r_bred         <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_result       <= '0;
      r_err          <= 1'b0;
      r_mod_start    <= 1'b0;
      r_mod_dividend <= '0;
      r_mod_divisor  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_base        <= i_base;
            r_exp         <= i_exp;
            r_mod_divisor <= i_modulus;
            // Degenerate moduli finish on the spot without touching mod_module.
            if (i_modulus <= BITS'(1)) begin
              r_done   <= 1'b1;
              r_err    <= (i_modulus == '0);
              r_result <= '0;
            end else begin
              r_busy  <= 1'b1;
              r_err   <= 1'b0;
              r_state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          r_acc          <= BITS'(1);
          r_op           <= OP_LOAD;
          r_mod_dividend <= {{BITS{1'b0}}, r_base};
`ifdef MODEXP_SKIP_LZ_EN
          r_state        <= (r_exp == '0) ? S_FIN : S_ISSUE;
`else
          r_state        <= S_ISSUE;
`endif
        end
        S_ISSUE: begin
          r_mod_start <= 1'b1;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          if (i_mod_done) begin
            if (r_op == OP_LOAD) r_bred <= i_mod_remainder;
            else                 r_acc  <= i_mod_remainder;
            r_mod_start <= 1'b0;
            r_state     <= S_GAP;
          end
        end
        S_GAP: begin
          r_state        <= S_ISSUE;
          r_mod_dividend <= w_prod;
          case (r_op)
            OP_LOAD: begin
              r_op <= OP_SQR;
              r_i  <= w_first_i;
            end
            OP_SQR: begin
              if (r_exp[r_i])     r_op    <= OP_MUL;
              else if (r_i == '0) r_state <= S_FIN;
              else                r_i     <= r_i - c_IW'(1);
            end
            default: begin
              if (r_i == '0) begin
                r_state <= S_FIN;
              end else begin
                r_op <= OP_SQR;
                r_i  <= r_i - c_IW'(1);
              end
            end
          endcase
        end
        S_FIN: begin
          r_result <= r_acc;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_result       = r_result;
  assign o_err          = r_err;
  assign o_mod_start    = r_mod_start;
  assign o_mod_dividend = r_mod_dividend;
  assign o_mod_divisor  = r_mod_divisor;

endmodule
`default_nettype wire

// File: tb/tb_rsa_modexp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rsa_modexp_ctrl
// Brief    : Scoreboard bench for rsa_modexp_ctrl with a random-latency
//            mod_module model and an arithmetic reference for base^exp mod n.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rsa_modexp_ctrl;

  localparam int BITS     = 32;
  localparam int EXP_BITS = 32;

  logic                clk       = 1'b0;
  logic                reset     = 1'b1;
  logic                i_start   = 1'b0;
  logic [BITS-1:0]     i_base    = '0;
  logic [EXP_BITS-1:0] i_exp     = '0;
  logic [BITS-1:0]     i_modulus = '0;
  logic                o_busy, o_done, o_err, o_mod_start;
  logic [BITS-1:0]     o_result, o_mod_divisor;
  logic [2*BITS-1:0]   o_mod_dividend;
  logic [BITS-1:0]     i_mod_remainder = '0;
  logic                i_mod_done      = 1'b0;

  int          checks     = 0;
  int          failures   = 0;
  int          done_seen  = 0;
  logic [63:0] div_q[$];
  logic [31:0] res_q[$];
  logic        err_q[$];
  logic [31:0] cur_mod    = '0;
  logic [31:0] last_res   = '0;
  bit          have_last  = 1'b0;

  rsa_modexp_ctrl #(.BITS(BITS), .EXP_BITS(EXP_BITS)) dut (
    .clk             (clk),
    .reset           (reset),
    .i_start         (i_start),
    .i_base          (i_base),
    .i_exp           (i_exp),
    .i_modulus       (i_modulus),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_result        (o_result),
    .o_err           (o_err),
    .o_mod_start     (o_mod_start),
    .o_mod_dividend  (o_mod_dividend),
    .o_mod_divisor   (o_mod_divisor),
    .i_mod_remainder (i_mod_remainder),
    .i_mod_done      (i_mod_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Right-to-left binary exponentiation: independent of the op sequence.
  function automatic logic [31:0] ref_pow(input logic [31:0] b, input logic [31:0] e,
                                          input logic [31:0] m);
    longint unsigned r, x, mm;
    logic [31:0] ee;
    if (m <= 1) return 32'd0;
    mm = m; r = 1; x = b % mm; ee = e;
    while (ee != 0) begin
      if (ee[0]) r = (r * x) % mm;
      x  = (x * x) % mm;
      ee = ee >> 1;
    end
    return r[31:0];
  endfunction

  // Dividends the controller must present, in order, for one exponentiation.
  task automatic build_trace(input logic [31:0] b, input logic [31:0] e, input logic [31:0] m);
    longint unsigned acc, br, mm, t;
    int top;
    div_q.delete();
    if (m <= 1) return;
    top = 31;
`ifdef MODEXP_SKIP_LZ_EN
    top = -1;
    for (int k = 0; k < 32; k++) if (e[k]) top = k;
    if (top < 0) return;
`endif
    mm = m; t = b;
    div_q.push_back(t);
    br = t % mm; acc = 1;
    for (int k = top; k >= 0; k--) begin
      div_q.push_back(acc * acc);
      acc = (acc * acc) % mm;
      if (e[k]) begin
        div_q.push_back(acc * br);
        acc = (acc * br) % mm;
      end
    end
  endtask

  function automatic logic [31:0] modrem(input logic [63:0] a, input logic [31:0] d);
    logic [63:0] q;
    if (d == 0) return 32'd0;
    q = a % {32'd0, d};
    return q[31:0];
  endfunction

  // mod_module model: random 1..20 cycle latency, stray done pulses while idle.
  initial begin : mod_model
    logic act, spur;
    int lat, cnt;
    logic [63:0] held;
    act = 1'b0; spur = 1'b0; lat = 0; cnt = 0; held = '0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        i_mod_done = 1'b0; act = 1'b0; spur = 1'b0;
      end else if (act && i_mod_done) begin
        i_mod_done = 1'b0; act = 1'b0;
        chk("mod_start_drop", o_mod_start, 0);
      end else if (act) begin
        chk("mod_start_hold", o_mod_start, 1);
        chk("dividend_stable", o_mod_dividend, held);
        cnt++;
        if (cnt >= lat) begin
          i_mod_done = 1'b1; i_mod_remainder = modrem(held, o_mod_divisor);
        end
      end else begin
        if (spur) begin
          i_mod_done = 1'b0; spur = 1'b0;
        end
        if (o_mod_start) begin
          act = 1'b1; held = o_mod_dividend; cnt = 1; lat = $urandom_range(1, 20);
          if (div_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_mod_op actual=0x%0h required=no op", o_mod_dividend);
          end else begin
            chk("mod_dividend", o_mod_dividend, div_q.pop_front());
          end
          chk("mod_divisor", o_mod_divisor, cur_mod);
          if (lat == 1) begin
            i_mod_done = 1'b1; i_mod_remainder = modrem(held, o_mod_divisor);
          end
        end else if ($urandom_range(0, 7) == 0) begin
          i_mod_done = 1'b1; i_mod_remainder = $urandom; spur = 1'b1;
        end
      end
    end
  end

  // Monitor: every done pulse is matched against the scoreboard queue.
  initial begin : monitor
    logic [31:0] r;
    logic e;
    forever begin
      @(negedge clk);
      if (!reset && o_done) begin
        done_seen++;
        if (res_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done actual=result 0x%0h required=no done", o_result);
        end else begin
          r = res_q.pop_front();
          e = err_q.pop_front();
          chk("result", o_result, r);
          chk("err", o_err, e);
          chk("busy_at_done", o_busy, 0);
          chk("ops_remaining", div_q.size(), 0);
        end
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_mod_start", o_mod_start, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_result", o_result, 0);
    res_q.delete(); err_q.delete(); div_q.delete();
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    last_res = '0; have_last = 1'b1;
  endtask

  task automatic run_op(input logic [31:0] b, input logic [31:0] e, input logic [31:0] m,
                        input bit poke, input bit mid_reset);
    int n, seen0;
    logic [31:0] expv;
    if (have_last) chk("result_held", o_result, last_res);
    build_trace(b, e, m);
    expv = ref_pow(b, e, m);
    res_q.push_back(expv);
    err_q.push_back(m == 0);
    cur_mod = m;
    seen0 = done_seen;
    @(posedge clk); #1;
    i_start = 1'b1; i_base = b; i_exp = e; i_modulus = m;
    @(posedge clk); #1;
    i_start = 1'b0;
    chk("busy_after_start", o_busy, (m > 1) ? 1 : 0);
    if (poke) begin
      for (int k = 0; k < 4; k++) @(posedge clk);
      #1;
      i_start = 1'b1; i_base = ~b; i_exp = e ^ 32'h5; i_modulus = m + 2;
      @(posedge clk); #1;
      i_start = 1'b0;
      chk("busy_after_poke", o_busy, 1);
    end
    if (mid_reset) begin
      n = 0;
      while (!o_mod_start && n < 200) begin
        @(posedge clk); #1; n++;
      end
      chk("mod_start_seen", o_mod_start, 1);
      apply_reset();
      return;
    end
    n = 0;
    while (done_seen == seen0 && n < 3000) begin
      @(posedge clk); n++;
    end
    chk("done_in_time", (done_seen != seen0) ? 1 : 0, 1);
    if (done_seen == seen0) begin
      apply_reset();
    end else begin
      #1;
      chk("done_pulse", o_done, 0);
      last_res = expv; have_last = 1'b1;
    end
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    logic [31:0] b, e, m;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", o_busy, 0);
    chk("reset_done", o_done, 0);
    chk("reset_result", o_result, 0);
    chk("reset_err", o_err, 0);
    chk("reset_mod_start", o_mod_start, 0);
    chk("reset_dividend", o_mod_dividend, 0);
    chk("reset_divisor", o_mod_divisor, 0);
    @(negedge clk);
    reset = 1'b0;

    run_op(32'd4, 32'd13, 32'd497, 1'b0, 1'b0);
    run_op(32'd2, 32'd10, 32'd1000, 1'b0, 1'b0);
    run_op(32'd1234, 32'd0, 32'd13, 1'b0, 1'b0);
    run_op(32'd5, 32'd3, 32'd1, 1'b0, 1'b0);
    run_op(32'd5, 32'd3, 32'd0, 1'b0, 1'b0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0, 1'b0);
    run_op(32'd7, 32'd65537, 32'd3233, 1'b1, 1'b0);
    run_op(32'd99, 32'h8000_0001, 32'd1_000_003, 1'b0, 1'b1);
    run_op(32'd3, 32'd5, 32'd7, 1'b0, 1'b0);

    for (int t = 0; t < 12; t++) begin
      b = $urandom;
      e = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) m = $urandom_range(2, 50);
      else m = $urandom;
      if (m < 2) m = 32'd3;
      run_op(b, e, m, 1'b0, 1'b0);
    end

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
